mc14500b_program_loader: RTL and testbench

//  Upstream stage of the MC14500B core. Takes a byte stream (valid/ready), assembles WORD-bit

---
 rtl/loader_pkg.sv | 28 ++
 rtl/word_assembler.sv | 42 ++++
 rtl/mc14500b_program_loader.sv | 148 ++++++++++++++
 tb/tb_mc14500b_program_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the MC14500B program loader.
// Contents:
//   loader_state_t  loader FSM states
//   nbyte(word)     bytes needed to carry one WORD-bit instruction
//   lbyte(addr)     bytes needed to carry the ADDR-bit length field
// Opcode encoding lives in the instructions package, not here.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StWhi,
    StWlo,
    StWrite,
    StCsum,
    StDone,
    StErr
  } loader_state_t;

  function automatic int unsigned nbyte(input int unsigned word);
    return (word + 7) / 8;
  endfunction

  function automatic int unsigned lbyte(input int unsigned addr);
    return (addr + 7) / 8;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Byte shift register that assembles one big-endian instruction word.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clear     zero the partial word
//   shift     shift data in at the low end
//   data      incoming byte
//   word      assembled word including the byte currently on data
//   rsv_bad   data has a nonzero bit where the first byte must carry zeros
// Only the low WORD-8 bits of earlier bytes are kept: anything above that
// falls off the top by the time the last byte arrives. Requires WORD > 8.
module word_assembler
  import loader_pkg::*;
#(
  parameter int unsigned WORD = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            shift,
  input  logic [7:0]      data,
  output logic [WORD-1:0] word,
  output logic            rsv_bad
);

  localparam int unsigned NBYTE   = nbyte(WORD);
  localparam int unsigned Unused  = 8 * NBYTE - WORD;
  localparam logic [7:0]  RsvMask = ~(8'hFF >> Unused);

  logic [WORD-9:0] sr;

  assign word    = {sr, data};
  assign rsv_bad = |(data & RsvMask);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr <= '0;
    end else if (shift) begin
      sr <= word[WORD-9:0];
    end
  end

endmodule

// File: rtl/mc14500b_program_loader.sv
// MC14500B program loader: receives a framed byte stream, writes the
// instructions into program memory and holds the core in reset until a
// load completes cleanly.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_req           start a load (ignored while busy)
//   in_valid/in_data   byte stream; in_ready = byte accepted this cycle
//   prog_write/addr/cmd  one-cycle program memory write
//   core_rst           1 holds the core in reset
//   busy, done, error  load in progress, completion pulse, sticky error
// Frame: length (LBYTE bytes, big-endian, 0 = full memory), then N
// instructions of NBYTE bytes each.
// Build option LOADER_CHECKSUM_EN: expect a trailing XOR checksum byte over
// every preceding frame byte; without it DONE follows the last write.
module mc14500b_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR = 8,
  parameter int unsigned CODE = 4,
  parameter int unsigned WORD = ADDR + CODE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_req,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            prog_write,
  output logic [ADDR-1:0] prog_addr,
  output logic [WORD-1:0] prog_cmd,
  output logic            core_rst,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int unsigned NBYTE    = nbyte(WORD);
  localparam int unsigned LBYTE    = lbyte(ADDR);
  localparam int unsigned LW       = 8 * LBYTE;
  localparam logic [3:0]  LastLen  = 4'(LBYTE - 1);
  localparam logic [3:0]  LastByte = 4'(NBYTE - 1);
  localparam logic [ADDR:0] MaxWords = {1'b1, {ADDR{1'b0}}};
  localparam logic [LW:0]   MaxLen   = (LW + 1)'(2 ** ADDR);

  loader_state_t state, state_d;

  logic [3:0]      lcnt, bcnt;
  logic [LW-1:0]   len_acc, len_full;
  logic [ADDR:0]   n, idx, idx_inc;
  logic [WORD-1:0] word_next;
  logic            rsv_bad, len_bad, accept, start, shift;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      csum;
`endif

  assign accept   = in_valid && in_ready;
  assign start    = load_req && (state inside {StIdle, StDone, StErr});
  assign shift    = accept && (state inside {StWhi, StWlo});
  assign len_full = (len_acc << 8) | LW'(in_data);
  assign len_bad  = {1'b0, len_full} > MaxLen;
  assign idx_inc  = idx + 1'b1;

  word_assembler #(
    .WORD (WORD)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .shift   (shift),
    .data    (in_data),
    .word    (word_next),
    .rsv_bad (rsv_bad)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      StIdle, StDone, StErr: if (load_req) state_d = StLen;
      StLen: if (accept && lcnt == LastLen) state_d = len_bad ? StErr : StWhi;
      StWhi: if (accept) state_d = rsv_bad ? StErr : StWlo;
      StWlo: if (accept && bcnt == LastByte) state_d = StWrite;
`ifdef LOADER_CHECKSUM_EN
      StWrite: state_d = (idx_inc == n) ? StCsum : StWhi;
      StCsum: if (accept) state_d = (in_data == csum) ? StDone : StErr;
`else
      StWrite: state_d = (idx_inc == n) ? StDone : StWhi;
      StCsum:  state_d = StErr;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      in_ready   <= 1'b0;
      prog_write <= 1'b0;
      prog_addr  <= '0;
      prog_cmd   <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      lcnt       <= '0;
      bcnt       <= '0;
      len_acc    <= '0;
      n          <= '0;
      idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      state      <= state_d;
      in_ready   <= state_d inside {StLen, StWhi, StWlo, StCsum};
      busy       <= state_d inside {StLen, StWhi, StWlo, StWrite, StCsum};
      prog_write <= state_d == StWrite;
      core_rst   <= state_d != StDone;
      done       <= (state_d == StDone) && (state != StDone);
      error      <= state_d == StErr;
      if (state_d == StWrite) begin
        prog_addr <= idx[ADDR-1:0];
        prog_cmd  <= word_next;
      end
      if (start) begin
        lcnt    <= '0;
        bcnt    <= '0;
        len_acc <= '0;
        idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum    <= '0;
`endif
      end
      if (accept && state == StLen) begin
        len_acc <= len_full;
        lcnt    <= lcnt + 4'd1;
        n       <= (len_full == '0) ? MaxWords : (ADDR + 1)'(len_full);
      end
      if (accept && state == StWhi) bcnt <= 4'd1;
      if (accept && state == StWlo) bcnt <= bcnt + 4'd1;
      if (state == StWrite) idx <= idx_inc;
`ifdef LOADER_CHECKSUM_EN
      if (accept && state != StCsum) csum <= csum ^ in_data;
`endif
    end
  end

endmodule

// File: tb/tb_mc14500b_program_loader.sv
module tb_mc14500b_program_loader;

  localparam int unsigned ADDR = 8;
  localparam int unsigned CODE = 4;
  localparam int unsigned WORD = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_req = 1'b0;
  logic            in_valid = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_ready, prog_write, core_rst, busy, done, error;
  logic [ADDR-1:0] prog_addr;
  logic [WORD-1:0] prog_cmd;

  mc14500b_program_loader #(
    .ADDR (ADDR),
    .CODE (CODE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .prog_write (prog_write),
    .prog_addr  (prog_addr),
    .prog_cmd   (prog_cmd),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef enum int {EvWrite = 0, EvDone = 1, EvErr = 2} ev_kind_e;
  typedef struct {
    int kind;
    int addr;
    int cmd;
  } ev_t;

  ev_t  sb[$];
  int   tests = 0;
  int   fails = 0;
  int   writes_seen = 0;
  logic err_prev = 1'b0;

  function automatic void check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endfunction

  function automatic void expect_ev(int kind, int addr, int cmd);
    ev_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d addr %0h cmd %0h, required none", kind, addr,
               cmd);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EvWrite && e.kind == EvWrite) begin
        check("write_addr", addr, e.addr);
        check("write_cmd", cmd, e.cmd);
      end
    end
  endfunction

  // Monitor: every write, done pulse and new error is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      err_prev <= 1'b0;
    end else begin
      if (prog_write) begin
        expect_ev(EvWrite, int'(prog_addr), int'(prog_cmd));
        writes_seen <= writes_seen + 1;
      end
      if (done) expect_ev(EvDone, 0, 0);
      if (error && !err_prev) expect_ev(EvErr, 0, 0);
      err_prev <= error;
    end
  end

  function automatic logic [7:0] xor_all(input logic [7:0] fr[$]);
    logic [7:0] x = 8'h00;
    foreach (fr[i]) x ^= fr[i];
    return x;
  endfunction

  // Reference model: parses a frame by its rules, queues the expected events and
  // returns how many bytes the loader should consume.
  function automatic int model(input logic [7:0] fr[$]);
    int         p;
    int         n;
    logic [7:0] x;
    logic [7:0] b0;
    ev_t        e;
    n = int'(fr[0]);
    x = fr[0];
    p = 1;
    if (n == 0) n = 256;
    for (int w = 0; w < n; w++) begin
      b0 = fr[p];
      if ((b0 & 8'hF0) != 8'h00) begin
        e.kind = EvErr; e.addr = 0; e.cmd = 0;
        sb.push_back(e);
        return p + 1;
      end
      e.kind = EvWrite;
      e.addr = w;
      e.cmd  = int'(b0[3:0]) * 256 + int'(fr[p+1]);
      sb.push_back(e);
      x ^= fr[p] ^ fr[p+1];
      p += 2;
    end
    e.addr = 0; e.cmd = 0;
`ifdef LOADER_CHECKSUM_EN
    e.kind = (fr[p] == x) ? EvDone : EvErr;
    sb.push_back(e);
    return p + 1;
`else
    e.kind = EvDone;
    sb.push_back(e);
    return p;
`endif
  endfunction

  task automatic send(input logic [7:0] fr[$], input int cnt, input bit gaps, input int stop_at);
    int t;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("busy_after_load_req", int'(busy), 1);
    check("core_rst_during_load", int'(core_rst), 1);
    check("error_cleared_by_load_req", int'(error), 0);
    for (int i = 0; i < cnt; i++) begin
      t = 0;
      forever begin
        @(negedge clk);
        if (stop_at > 0 && writes_seen >= stop_at) begin
          in_valid = 1'b0;
          return;
        end
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = fr[i];
        if (in_valid && in_ready) break;
        t++;
        if (t > 50) begin
          tests++;
          fails++;
          $display("FAIL byte_accept_timeout: byte %0d not accepted, required within 50 cycles", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic no_accept(string name, input logic [7:0] b);
    int hits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    repeat (10) begin
      if (in_ready) hits++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check(name, hits, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] base[$];
    int c, w0, bad_idle, nw;

    // Reset state and idle behaviour
    repeat (3) @(negedge clk);
    check("rst_core_rst", int'(core_rst), 1);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_prog_write", int'(prog_write), 0);
    check("rst_prog_addr", int'(prog_addr), 0);
    check("rst_prog_cmd", int'(prog_cmd), 0);
    rst = 1'b0;
    bad_idle = 0;
    repeat (20) begin
      @(negedge clk);
      if (prog_write || busy || in_ready || !core_rst) bad_idle++;
    end
    check("idle_20_cycles", bad_idle, 0);

    // Three-word frame
    base = '{8'h03, 8'h0A, 8'h15, 8'h03, 8'hFF, 8'h0F, 8'h01};
    fr = base;
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(xor_all(base));
`endif
    c = model(fr);
    send(fr, c, 1'b0, 0);
    drain("frame3_events");
    check("frame3_core_rst", int'(core_rst), 0);
    check("frame3_busy", int'(busy), 0);

    // Length 0: full 256-word memory with gaps
    fr.delete();
    fr.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      fr.push_back(8'h00);
      fr.push_back(8'(i));
    end
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(xor_all(fr));
`endif
    c = model(fr);
    send(fr, c, 1'b1, 0);
    drain("full_mem_events");
    check("full_mem_last_addr", int'(prog_addr), 8'hFF);
    check("full_mem_core_rst", int'(core_rst), 0);
    no_accept("full_mem_no_extra_byte", 8'h55);

    // Reserved bit set in the second word's first byte
    fr = '{8'h02, 8'h01, 8'h23, 8'h1A, 8'h00};
    c = model(fr);
    send(fr, c, 1'b0, 0);
    drain("reserved_events");
    check("reserved_error", int'(error), 1);
    check("reserved_core_rst", int'(core_rst), 1);
    check("reserved_busy", int'(busy), 0);

    // Bad trailing checksum byte
    fr = base;
    fr.push_back(xor_all(base) ^ 8'h5A);
    c = model(fr);
    send(fr, c, 1'b0, 0);
    drain("bad_csum_events");
`ifdef LOADER_CHECKSUM_EN
    check("bad_csum_error", int'(error), 1);
    check("bad_csum_core_rst", int'(core_rst), 1);
`else
    check("trailing_core_rst", int'(core_rst), 0);
    no_accept("trailing_not_accepted", fr[7]);
`endif

    // Random frames
    for (int k = 0; k < 8; k++) begin
      fr.delete();
      nw = $urandom_range(1, 6);
      fr.push_back(8'(nw));
      for (int w = 0; w < nw; w++) begin
        fr.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255))
                                                 : 8'($urandom_range(0, 15)));
        fr.push_back(8'($urandom));
      end
`ifdef LOADER_CHECKSUM_EN
      fr.push_back(($urandom_range(0, 3) == 0) ? (xor_all(fr) ^ 8'h01) : xor_all(fr));
`endif
      c = model(fr);
      send(fr, c, 1'b1, 0);
      drain("random_frame_events");
    end

    // Reset in the middle of a load
    fr = '{8'h05, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33, 8'h04, 8'h44, 8'h05, 8'h55};
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(xor_all(fr));
`endif
    c = model(fr);
    w0 = writes_seen;
    send(fr, c, 1'b0, w0 + 2);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_core_rst", int'(core_rst), 1);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_writes_before", writes_seen - w0, 2);
    rst = 1'b0;
    fr = base;
`ifdef LOADER_CHECKSUM_EN
    fr.push_back(xor_all(base));
`endif
    c = model(fr);
    send(fr, c, 1'b1, 0);
    drain("after_rst_events");
    check("after_rst_core_rst", int'(core_rst), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
